// File: rtl/pwm_led_pkg.sv
// pwm_led_pkg: register offsets, bus FSM states and byte-strobe helper for pwm_led_controller
package pwm_led_pkg;
    localparam logic [7:0] OFS_DATA      = 8'h00;
    localparam logic [7:0] OFS_MODE      = 8'h04;
    localparam logic [7:0] OFS_BLINK     = 8'h08;
    localparam logic [7:0] OFS_PRESCALE  = 8'h0C;
    localparam logic [7:0] OFS_DUTY_BASE = 8'h10;
    typedef enum logic {IDLE, RESP} bus_state_t;
    function automatic logic [31:0] strobe_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction
endpackage

// File: rtl/led_timebase.sv
// led_timebase: shared prescaler, PWM counter and blink phase generator
module led_timebase #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         prescale,
    input  logic [15:0]         blink,
    input  logic                prescale_wr,
    input  logic                blink_wr,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                blink_phase
);
    logic [15:0] pre_cnt;
    logic [15:0] blink_cnt;
    logic        tick;
    logic        period_end;
    logic        blink_last;
    always_comb begin
        tick       = (pre_cnt == prescale) && !prescale_wr;
        period_end = tick && (pwm_cnt == '1);
        blink_last = blink_cnt == blink - 16'd1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            pre_cnt <= (prescale_wr || tick) ? '0 : pre_cnt + 16'd1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            // BLINK=0 pins the phase high so blink-mode channels behave as steady
            if (blink_wr || blink == '0) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (period_end) begin
                blink_cnt   <= blink_last ? '0 : blink_cnt + 16'd1;
                blink_phase <= blink_last ? ~blink_phase : blink_phase;
            end
        end
    end
endmodule

// File: rtl/pwm_led_controller.sv
// pwm_led_controller: memory-mapped LED driver with per-channel PWM brightness and blink
module pwm_led_controller
    import pwm_led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic [31:0]         mem_rdata,
    output logic [NUM_LEDS-1:0] led
);
    bus_state_t          state, state_nxt;
    logic [NUM_LEDS-1:0] data, mode, pwm_on;
    logic [15:0]         blink, prescale;
    logic [PWM_BITS-1:0] duty [NUM_LEDS];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_phase;
    logic [5:0]          word, duty_idx;
    logic                duty_hit, accept, wr, prescale_wr, blink_wr;
    logic [31:0]         rd_val, wval, rdata_q;
    logic                unused_bits;
    always_comb begin
        word     = mem_addr[7:2];
        // offsets below the duty block wrap to large indices and miss
        duty_idx = word - OFS_DUTY_BASE[7:2];
        duty_hit = 32'(duty_idx) < NUM_LEDS;
        accept   = state == IDLE && mem_valid;
        wr       = accept && mem_wstrb != 4'b0000;
        rd_val   = '0;
        if (word == OFS_DATA[7:2])     rd_val = 32'(data);
        if (word == OFS_MODE[7:2])     rd_val = 32'(mode);
        if (word == OFS_BLINK[7:2])    rd_val = 32'(blink);
        if (word == OFS_PRESCALE[7:2]) rd_val = 32'(prescale);
        for (int i = 0; i < NUM_LEDS; i++)
            if (duty_hit && duty_idx == 6'(i)) rd_val = 32'(duty[i]);
        wval        = (rd_val & ~strobe_mask(mem_wstrb)) | (mem_wdata & strobe_mask(mem_wstrb));
        prescale_wr = wr && word == OFS_PRESCALE[7:2];
        blink_wr    = wr && word == OFS_BLINK[7:2];
        state_nxt   = accept ? RESP : IDLE;
        mem_ready   = state == RESP;
        mem_rdata   = mem_ready ? rdata_q : '0;
        for (int i = 0; i < NUM_LEDS; i++)
            pwm_on[i] = duty[i] == '1 || pwm_cnt < duty[i];
        unused_bits = ^{mem_addr[31:8], mem_addr[1:0], wval};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            rdata_q <= accept ? rd_val : rdata_q;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= '0;
            mode     <= '0;
            blink    <= '0;
            prescale <= '0;
            led      <= '0;
            for (int i = 0; i < NUM_LEDS; i++) duty[i] <= '1;
        end else begin
            led <= data & pwm_on & (~mode | {NUM_LEDS{blink_phase}});
            if (wr && word == OFS_DATA[7:2]) data <= wval[NUM_LEDS-1:0];
            if (wr && word == OFS_MODE[7:2]) mode <= wval[NUM_LEDS-1:0];
            if (blink_wr)    blink    <= wval[15:0];
            if (prescale_wr) prescale <= wval[15:0];
            for (int i = 0; i < NUM_LEDS; i++)
                if (wr && duty_hit && duty_idx == 6'(i)) duty[i] <= wval[PWM_BITS-1:0];
        end
    end
    led_timebase #(.PWM_BITS(PWM_BITS)) u_timebase (
        .clk        (clk),
        .reset_n    (reset_n),
        .prescale   (prescale),
        .blink      (blink),
        .prescale_wr(prescale_wr),
        .blink_wr   (blink_wr),
        .pwm_cnt    (pwm_cnt),
        .blink_phase(blink_phase)
    );
endmodule

// File: tb/tb_pwm_led_controller.sv
// tb_pwm_led_controller: directed table plus multi-cycle sequences for pwm_led_controller
module tb_pwm_led_controller;
    logic        clk = 1'b0, reset_n = 1'b0, mem_valid = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready, ready16;
    logic [31:0] mem_rdata, rdata16;
    logic [7:0]  led;
    logic [15:0] led16;
    int          checks = 0, errors = 0;
    logic [7:0]  led_at_ready;
    logic [31:0] rd16, r;
    int          c;
    logic [4:0]  pat;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [30];

    pwm_led_controller #(.NUM_LEDS(8), .PWM_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .led(led)
    );
    pwm_led_controller #(.NUM_LEDS(16), .PWM_BITS(8)) dut16 (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_ready(ready16),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(rdata16), .led(led16)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                          output logic [31:0] rd);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = w; mem_wstrb = s;
        @(posedge clk);
        #1 mem_valid = 1'b0; mem_wstrb = 4'b0000;
        @(negedge clk);
        check("ready_pulse", {31'd0, mem_ready}, 32'd1);
        rd = mem_rdata; rd16 = rdata16; led_at_ready = led;
        @(negedge clk);
        check("ready_drop", {31'd0, mem_ready}, 32'd0);
        check("rdata_idle", mem_rdata, 32'd0);
    endtask

    task automatic count_high(input int b, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(led[b]);
        end
    endtask

    task automatic wait_toggle(output int n);
        logic prev;
        prev = led[1];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led[1] == prev && n < 1000);
    endtask

    initial begin
        vt[0]  = '{32'h00, 32'h0, 4'h0, 32'h0};
        vt[1]  = '{32'h04, 32'h0, 4'h0, 32'h0};
        vt[2]  = '{32'h08, 32'h0, 4'h0, 32'h0};
        vt[3]  = '{32'h0C, 32'h0, 4'h0, 32'h0};
        vt[4]  = '{32'h1C, 32'h0, 4'h0, 32'hFF};
        vt[5]  = '{32'h2C, 32'h0, 4'h0, 32'hFF};
        vt[6]  = '{32'h30, 32'h0, 4'h0, 32'h0};
        vt[7]  = '{32'h9C, 32'h0, 4'h0, 32'h0};
        vt[8]  = '{32'h04, 32'h12345678, 4'hF, 32'h0};
        vt[9]  = '{32'h04, 32'h0, 4'h0, 32'h78};
        vt[10] = '{32'h04, 32'h0, 4'hF, 32'h0};
        vt[11] = '{32'h04, 32'h0, 4'h0, 32'h0};
        vt[12] = '{32'h08, 32'hABCD1234, 4'hF, 32'h0};
        vt[13] = '{32'h08, 32'h0, 4'h0, 32'h1234};
        vt[14] = '{32'h08, 32'h0, 4'h3, 32'h0};
        vt[15] = '{32'h08, 32'h0, 4'h0, 32'h0};
        vt[16] = '{32'h0C, 32'h00FF0042, 4'h1, 32'h0};
        vt[17] = '{32'h0C, 32'h0, 4'h0, 32'h42};
        vt[18] = '{32'h0C, 32'hFFFF0000, 4'h3, 32'h0};
        vt[19] = '{32'h0C, 32'h0, 4'h0, 32'h0};
        vt[20] = '{32'h20, 32'h1234, 4'h2, 32'h0};
        vt[21] = '{32'h20, 32'h0, 4'h0, 32'hFF};
        vt[22] = '{32'h20, 32'h33, 4'h1, 32'h0};
        vt[23] = '{32'h20, 32'h0, 4'h0, 32'h33};
        vt[24] = '{32'h20, 32'hFF, 4'h1, 32'h0};
        vt[25] = '{32'h20, 32'h0, 4'h0, 32'hFF};
        vt[26] = '{32'h10, 32'hAB, 4'h1, 32'h0};
        vt[27] = '{32'h13, 32'h0, 4'h0, 32'hAB};
        vt[28] = '{32'h113, 32'h0, 4'h0, 32'hAB};
        vt[29] = '{32'h10, 32'hFF, 4'hF, 32'h0};

        repeat (3) @(negedge clk);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_led", {24'd0, led}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            access(vt[i].addr, vt[i].wdata, vt[i].wstrb, r);
            if (vt[i].wstrb == 4'h0) check($sformatf("vec%0d", i), r, vt[i].exp);
        end

        access(32'h00, 32'hA5, 4'hF, r);
        check("led_before_update", {24'd0, led_at_ready}, 32'd0);
        check("led_after_update", {24'd0, led}, 32'hA5);
        access(32'h00, 32'h0, 4'h0, r);
        check("data_readback", r, 32'hA5);

        access(32'h00, 32'h3C00, 4'h2, r);
        access(32'h00, 32'h0, 4'h0, r);
        check("strobe_n8", r, 32'hA5);
        check("strobe_n16", rd16, 32'h3CA5);

        access(32'h10, 32'd64, 4'hF, r);
        access(32'h00, 32'h01, 4'hF, r);
        count_high(0, 256, c);
        check("pwm64_a", c, 64);
        count_high(0, 256, c);
        check("pwm64_b", c, 64);
        access(32'h0C, 32'h1, 4'h1, r);
        count_high(0, 512, c);
        check("pwm64_pre1", c, 128);
        access(32'h0C, 32'h0, 4'h1, r);
        access(32'h10, 32'd0, 4'hF, r);
        count_high(0, 256, c);
        check("pwm_duty0", c, 0);
        access(32'h10, 32'd255, 4'hF, r);
        count_high(0, 256, c);
        check("pwm_duty255", c, 256);

        access(32'h04, 32'h02, 4'hF, r);
        access(32'h00, 32'h02, 4'hF, r);
        access(32'h14, 32'hFF, 4'hF, r);
        access(32'h08, 32'h2, 4'hF, r);
        check("blink_start", {31'd0, led[1]}, 32'd1);
        wait_toggle(c);
        check("blink_first_edge", {31'd0, c < 1000}, 32'd1);
        wait_toggle(c);
        check("blink_half1", c, 512);
        wait_toggle(c);
        check("blink_half2", c, 512);
        access(32'h04, 32'h00, 4'hF, r);
        count_high(1, 1024, c);
        check("blink_off_steady", c, 1024);

        access(32'h9C, 32'hFFFFFFFF, 4'hF, r);
        pat = 5'b01010;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h00; mem_wstrb = 4'h0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("hold_ready%0d", k), {31'd0, mem_ready}, {31'd0, pat[k]});
            if (pat[k]) check("hold_rdata", mem_rdata, 32'h02);
        end
        mem_valid = 1'b0;
        access(32'h04, 32'h0, 4'h0, r);
        check("unmapped_mode", r, 32'h0);
        access(32'h08, 32'h0, 4'h0, r);
        check("unmapped_blink", r, 32'h2);

        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h00; mem_wstrb = 4'h0;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        @(negedge clk);
        check("resp_ready", {31'd0, mem_ready}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_in_resp_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_in_resp_rdata", mem_rdata, 32'd0);
        check("rst_in_resp_led", {24'd0, led}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        access(32'h00, 32'h0, 4'h0, r);
        check("rst_data", r, 32'h0);
        access(32'h10, 32'h0, 4'h0, r);
        check("rst_duty0", r, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
